// File: rtl/ucsbece154_mem_arbiter.sv
// Two-port round-robin read arbiter sharing one SDRAM read channel between the
// instruction-cache (port 0) and data-cache (port 1) refill ports.
module ucsbece154_mem_arbiter #(
    parameter int unsigned BLOCK_WORDS = 4,
    parameter int unsigned WORD_SIZE   = 32,
    parameter int unsigned ADDR_WIDTH  = 32
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Req0ReadRequest,
    input  logic [ADDR_WIDTH-1:0] Req0ReadAddress,
    output logic [WORD_SIZE-1:0]  Req0DataIn,
    output logic                  Req0DataReady,
    input  logic                  Req1ReadRequest,
    input  logic [ADDR_WIDTH-1:0] Req1ReadAddress,
    output logic [WORD_SIZE-1:0]  Req1DataIn,
    output logic                  Req1DataReady,
    output logic                  MemReadRequest,
    output logic [ADDR_WIDTH-1:0] MemReadAddress,
    input  logic [WORD_SIZE-1:0]  MemDataIn,
    input  logic                  MemDataReady,
    output logic [1:0]            Grant,
    output logic                  Busy
);

    localparam int unsigned CW          = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam int unsigned BLOCK_BYTES = BLOCK_WORDS * WORD_SIZE / 8;
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(BLOCK_BYTES - 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BLOCK_WORDS - 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                state;
    logic [CW-1:0]         beat_count;
    logic                  ptr;        // 1: port 1 wins the next contended grant
    logic                  win1;
    logic [ADDR_WIDTH-1:0] sel_addr;

    always_comb begin
        win1     = Req1ReadRequest && (!Req0ReadRequest || ptr);
        sel_addr = win1 ? Req1ReadAddress : Req0ReadAddress;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state          <= IDLE;
            MemReadRequest <= 1'b0;
            MemReadAddress <= '0;
            Grant          <= '0;
            Busy           <= 1'b0;
            beat_count     <= '0;
            ptr            <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Req0ReadRequest || Req1ReadRequest) begin
                        state          <= BURST;
                        MemReadRequest <= 1'b1;
                        MemReadAddress <= sel_addr & ADDR_MASK;
                        Grant          <= win1 ? 2'b10 : 2'b01;
                        Busy           <= 1'b1;
                        ptr            <= ~win1;
                    end
                end
                BURST: begin
                    if (MemDataReady) begin
                        if (beat_count == LAST_BEAT) begin
                            beat_count     <= '0;
                            state          <= IDLE;
                            MemReadRequest <= 1'b0;
                            Grant          <= '0;
                            Busy           <= 1'b0;
                        end else begin
                            beat_count <= beat_count + CW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Beat data is broadcast; only the granted port's ready qualifies it.
    always_comb begin
        Req0DataIn    = MemDataIn;
        Req1DataIn    = MemDataIn;
        Req0DataReady = (state == BURST) && MemDataReady && Grant[0];
        Req1DataReady = (state == BURST) && MemDataReady && Grant[1];
    end

endmodule

// File: tb/tb_ucsbece154_mem_arbiter.sv
// Scoreboard bench for ucsbece154_mem_arbiter: expected beats are queued when
// driven on the memory side and popped when a port reports DataReady.
module tb_ucsbece154_mem_arbiter;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Req0ReadRequest, Req1ReadRequest;
    logic [31:0] Req0ReadAddress, Req1ReadAddress;
    logic [31:0] Req0DataIn, Req1DataIn;
    logic        Req0DataReady, Req1DataReady;
    logic        MemReadRequest;
    logic [31:0] MemReadAddress;
    logic [31:0] MemDataIn;
    logic        MemDataReady;
    logic [1:0]  Grant;
    logic        Busy;

    typedef struct packed {
        logic        port;
        logic [31:0] data;
    } beat_t;

    beat_t sb[$];
    int    n_checks = 0;
    int    n_fails  = 0;

    always #5 Clk = ~Clk;

    ucsbece154_mem_arbiter #(
        .BLOCK_WORDS(4),
        .WORD_SIZE(32),
        .ADDR_WIDTH(32)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .Req0ReadRequest(Req0ReadRequest),
        .Req0ReadAddress(Req0ReadAddress),
        .Req0DataIn(Req0DataIn),
        .Req0DataReady(Req0DataReady),
        .Req1ReadRequest(Req1ReadRequest),
        .Req1ReadAddress(Req1ReadAddress),
        .Req1DataIn(Req1DataIn),
        .Req1DataReady(Req1DataReady),
        .MemReadRequest(MemReadRequest),
        .MemReadAddress(MemReadAddress),
        .MemDataIn(MemDataIn),
        .MemDataReady(MemDataReady),
        .Grant(Grant),
        .Busy(Busy)
    );

    // Advance one cycle; at the falling edge any port beat is matched against the scoreboard.
    task automatic step();
        beat_t e;
        logic  got_port;
        logic [31:0] got_data;
        @(negedge Clk);
        if (Req0DataReady || Req1DataReady) begin
            n_checks++;
            got_port = Req1DataReady;
            got_data = got_port ? Req1DataIn : Req0DataIn;
            if (Req0DataReady && Req1DataReady) begin
                n_fails++;
                $display("FAIL both_ready: got ready0=%b ready1=%b expected only one", Req0DataReady, Req1DataReady);
            end else if (sb.size() == 0) begin
                n_fails++;
                $display("FAIL unexpected_beat: got port%0d data=%h expected no beat", got_port, got_data);
            end else begin
                e = sb.pop_front();
                if (got_port !== e.port || got_data !== e.data) begin
                    n_fails++;
                    $display("FAIL beat: got port%0d data=%h expected port%0d data=%h", got_port, got_data, e.port, e.data);
                end
            end
        end
        @(posedge Clk);
        #1;
    endtask

    // Drives four beats for the granted port; at drop_idx both requests fall and addresses are scrambled.
    task automatic run_burst(input logic port, input logic [31:0] base, input logic [31:0] exp_addr, input int drop_idx);
        for (int i = 0; i < 4; i++) begin
            if (i == drop_idx) begin
                Req0ReadRequest = 1'b0;
                Req1ReadRequest = 1'b0;
                Req0ReadAddress = 32'hFFFF_FFF8;
                Req1ReadAddress = 32'hFFFF_FFF8;
            end
            n_checks++;
            if (Grant !== (port ? 2'b10 : 2'b01) || Busy !== 1'b1 || MemReadRequest !== 1'b1 || MemReadAddress !== exp_addr) begin
                n_fails++;
                $display("FAIL burst_hold beat%0d: got grant=%b busy=%b req=%b addr=%h expected grant=%b busy=1 req=1 addr=%h",
                         i, Grant, Busy, MemReadRequest, MemReadAddress, port ? 2'b10 : 2'b01, exp_addr);
            end
            MemDataIn    = base + 32'(i);
            MemDataReady = 1'b1;
            sb.push_back('{port: port, data: base + 32'(i)});
            step();
        end
        MemDataReady = 1'b0;
        n_checks++;
        if (MemReadRequest !== 1'b0 || Grant !== 2'b00 || Busy !== 1'b0) begin
            n_fails++;
            $display("FAIL burst_end: got req=%b grant=%b busy=%b expected req=0 grant=00 busy=0", MemReadRequest, Grant, Busy);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Req0ReadRequest = 1'b0; Req1ReadRequest = 1'b0;
        Req0ReadAddress = '0;   Req1ReadAddress = '0;
        MemDataIn = '0;         MemDataReady = 1'b0;
        step(); step();
        Reset = 1'b0;
        n_checks++;
        if (MemReadRequest !== 1'b0 || MemReadAddress !== 32'h0 || Grant !== 2'b00 || Busy !== 1'b0) begin
            n_fails++;
            $display("FAIL reset: got req=%b addr=%h grant=%b busy=%b expected 0/0/00/0", MemReadRequest, MemReadAddress, Grant, Busy);
        end
    endtask

    task automatic test_single_port0();
        Req0ReadRequest = 1'b1;
        Req0ReadAddress = 32'h0000_1234;
        step();
        run_burst(1'b0, 32'hA0, 32'h0000_1230, 3);
        step();
        n_checks++;
        if (Grant !== 2'b00 || sb.size() != 0) begin
            n_fails++;
            $display("FAIL single_idle: got grant=%b pending=%0d expected grant=00 pending=0", Grant, sb.size());
        end
    endtask

    task automatic test_contention();
        logic exp_port;
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        Req0ReadRequest = 1'b1; Req0ReadAddress = 32'h0000_1234;
        Req1ReadRequest = 1'b1; Req1ReadAddress = 32'h0000_ABCD;
        for (int k = 0; k < 4; k++) begin
            exp_port = k[0];
            step();
            n_checks++;
            if (Grant !== (exp_port ? 2'b10 : 2'b01)) begin
                n_fails++;
                $display("FAIL rr_grant%0d: got grant=%b expected grant=%b", k, Grant, exp_port ? 2'b10 : 2'b01);
            end
            run_burst(exp_port, 32'hB0 + 32'(k * 16), exp_port ? 32'h0000_ABC0 : 32'h0000_1230, (k == 3) ? 3 : -1);
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fails++;
            $display("FAIL rr_drain: got pending=%0d expected 0", sb.size());
        end
    endtask

    task automatic test_drop_midburst();
        Req1ReadRequest = 1'b1;
        Req1ReadAddress = 32'h0000_5558;
        step();
        run_burst(1'b1, 32'hC0, 32'h0000_5550, 1);
        step();
        n_checks++;
        if (Grant !== 2'b00 || MemReadRequest !== 1'b0 || sb.size() != 0) begin
            n_fails++;
            $display("FAIL drop_idle: got grant=%b req=%b pending=%0d expected 00/0/0", Grant, MemReadRequest, sb.size());
        end
    endtask

    task automatic test_reset_midburst();
        Req0ReadRequest = 1'b1;
        Req0ReadAddress = 32'h0000_2000;
        step();
        for (int i = 0; i < 2; i++) begin
            MemDataIn = 32'hD0 + 32'(i); MemDataReady = 1'b1;
            sb.push_back('{port: 1'b0, data: 32'hD0 + 32'(i)});
            step();
        end
        MemDataReady = 1'b0;
        Reset = 1'b1;
        Req0ReadRequest = 1'b0;
        step();
        Reset = 1'b0;
        n_checks++;
        if (MemReadRequest !== 1'b0 || Grant !== 2'b00 || Busy !== 1'b0) begin
            n_fails++;
            $display("FAIL midreset: got req=%b grant=%b busy=%b expected 0/00/0", MemReadRequest, Grant, Busy);
        end
        // Leftover beats from the aborted burst must not reach any port.
        MemDataReady = 1'b1; MemDataIn = 32'hD2; step();
        MemDataIn = 32'hD3; step();
        MemDataReady = 1'b0;
        Req0ReadRequest = 1'b1;
        Req0ReadAddress = 32'h0000_3004;
        step();
        run_burst(1'b0, 32'hE0, 32'h0000_3000, 3);
        n_checks++;
        if (sb.size() != 0) begin
            n_fails++;
            $display("FAIL midreset_drain: got pending=%0d expected 0", sb.size());
        end
    endtask

    task automatic test_idle_beats();
        MemDataReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            MemDataIn = 32'h70 + 32'(i);
            step();
        end
        MemDataReady = 1'b0;
        Req1ReadRequest = 1'b1;
        Req1ReadAddress = 32'h0000_0044;
        step();
        run_burst(1'b1, 32'hF0, 32'h0000_0040, 3);
        step();
        n_checks++;
        if (Busy !== 1'b0 || sb.size() != 0) begin
            n_fails++;
            $display("FAIL idle_beats: got busy=%b pending=%0d expected 0/0", Busy, sb.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3];
        logic [31:0] exp   [3];
        addrs[0] = 32'h0000_0100; exp[0] = 32'h0000_0100;
        addrs[1] = 32'h0000_0257; exp[1] = 32'h0000_0250;
        addrs[2] = 32'h0000_03F8; exp[2] = 32'h0000_03F0;
        Req0ReadRequest = 1'b1;
        Req0ReadAddress = addrs[0];
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (Grant !== 2'b01 || MemReadAddress !== exp[k]) begin
                n_fails++;
                $display("FAIL b2b_grant%0d: got grant=%b addr=%h expected grant=01 addr=%h", k, Grant, MemReadAddress, exp[k]);
            end
            run_burst(1'b0, 32'h200 + 32'(k * 16), exp[k], (k == 2) ? 3 : -1);
            if (k < 2) Req0ReadAddress = addrs[k + 1];
        end
        step();
        n_checks++;
        if (Grant !== 2'b00 || sb.size() != 0) begin
            n_fails++;
            $display("FAIL b2b_end: got grant=%b pending=%0d expected 00/0", Grant, sb.size());
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_single_port0();
        test_contention();
        test_drop_midburst();
        test_reset_midburst();
        test_idle_beats();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
